skid_pipe_reg: RTL and testbench

- Single-entry pipeline register with valid/ready handshake and a one-entry skid buffer.
- Sits directly upstream of the enabled flip-flop stages. It converts a producer's valid/ready stream into registered data, so downstream consumers can stall without a combinational ready path back to the producer.
- Full throughput (one transfer per cycle) when not stalled. It buffers exactly one extra beat when the consumer stalls.

---
 rtl/skid_pipe_reg.sv | 158 +++++++++++++++
 tb/tb_skid_pipe_reg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/skid_pipe_reg.sv
// ---------------------------------------------------------------------------
// skid_pipe_reg
//
// Single-entry pipeline register with a valid/ready handshake and a
// one-entry skid buffer. The producer-facing ready is a flop, so a stalled
// consumer never creates a combinational path back to the producer. One
// transfer per cycle while the consumer keeps up. When the consumer stalls,
// exactly one extra beat is absorbed in the skid register.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (registered, depends only on state)
//   in_data    upstream payload, WIDTH bits
//   out_valid  registered beat present on out_data
//   out_ready  downstream accepts the beat on out_data
//   out_data   registered payload, WIDTH bits (keeps last value when idle)
//   occupancy  number of beats held: 0, 1 or 2
// ---------------------------------------------------------------------------
module skid_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // INIT exists so that in_ready only rises one edge after reset release;
    // EMPTY/BUSY/FULL correspond to zero, one and two held beats.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        EMPTY = 2'd1,
        BUSY  = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       occ_q, occ_d;

    logic             in_fire;
    logic             out_fire;

    // Handshakes are judged against the registered flags, which are exactly
    // the values the outside world sees this cycle.
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Next-state and datapath selection. The main register always holds the
    // oldest beat; the skid register holds the younger one only in FULL.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            INIT: begin
                state_d = EMPTY;
            end
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_valid is ignored here; in_ready is low so nothing fires.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Status flags are decoded from the next state and then registered, so
    // every output is a flop output with no path from any input.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        occ_d       = 2'd0;
        case (state_d)
            INIT: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                occ_d       = 2'd0;
            end
            EMPTY: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                occ_d       = 2'd0;
            end
            BUSY: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b1;
                occ_d       = 2'd1;
            end
            FULL: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                occ_d       = 2'd2;
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                occ_d       = 2'd0;
            end
        endcase
    end

    // State and storage. Reset discards both held beats immediately,
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_skid_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_skid_pipe_reg
//
// Self-checking bench for skid_pipe_reg. A queue-based model tracks the
// beats held by the stage; a negedge compare process checks every DUT
// output against it, and directed sections pin the model with literal
// expectations. Ends with a random soak.
// ---------------------------------------------------------------------------
module tb_skid_pipe_reg;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int checks = 0;
    int errors = 0;

    // Model state: queue of held beats, oldest first.
    logic [7:0] mq[$];
    logic       mInit       = 1'b1;
    logic [7:0] mHead       = 8'h00;
    logic       pendValid   = 1'b0;
    logic [7:0] pendData    = 8'h00;
    logic       protoCheckEn = 1'b1;

    skid_pipe_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic modelReady();
        return !mInit && (mq.size() < 2);
    endfunction

    // Model update on each edge: pop the oldest beat if the consumer takes
    // it, append a new beat if the stage could accept one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mInit     = 1'b1;
            mHead     = 8'h00;
            pendValid = 1'b0;
        end else if (mInit) begin
            mInit     = 1'b0;
            pendValid = 1'b0;
        end else begin
            logic rdy, inFire, outFire;
            if (protoCheckEn && pendValid) begin
                checkOutput("producer_hold_valid", 32'(in_valid), 32'd1);
                checkOutput("producer_hold_data", 32'(in_data), 32'(pendData));
            end
            rdy     = mq.size() < 2;
            inFire  = in_valid && rdy;
            outFire = (mq.size() > 0) && out_ready;
            if (outFire) void'(mq.pop_front());
            if (inFire) mq.push_back(in_data);
            if (mq.size() > 0) mHead = mq[0];
            pendValid = in_valid && !inFire;
            pendData  = in_data;
        end
    end

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        checkOutput("cmp_in_ready", 32'(in_ready), 32'(modelReady()));
        checkOutput("cmp_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        checkOutput("cmp_occupancy", 32'(occupancy), 32'(mq.size()));
        checkOutput("cmp_out_data", 32'(out_data), 32'(mHead));
        if (!mInit && !rst)
            checkOutput("ready_vs_occ", 32'(in_ready), 32'(occupancy < 2'd2));
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset with a beat waiting on the input.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        end
        rst = 1'b0;
        #1;
        checkOutput("init_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_init_in_ready", 32'(in_ready), 32'd1);
        checkOutput("a5_not_taken", 32'(out_valid), 32'd0);
        checkOutput("a5_not_taken_occ", 32'(occupancy), 32'd0);

        // Streaming 01..10 with the consumer always ready.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
            stepCycle();
            checkOutput("stream_data", 32'(out_data), 32'(i));
            checkOutput("stream_valid", 32'(out_valid), 32'd1);
            checkOutput("stream_occ", 32'(occupancy), 32'd1);
            checkOutput("stream_ready", 32'(in_ready), 32'd1);
        end

        // Stall and skid: BUSY with 11, then 22 arrives while stalled.
        applyStimulus(1'b1, 8'h11, 1'b1);
        stepCycle();
        checkOutput("busy_11", 32'(out_data), 32'h11);
        applyStimulus(1'b1, 8'h22, 1'b0);
        stepCycle();
        checkOutput("full_occ", 32'(occupancy), 32'd2);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        checkOutput("full_data", 32'(out_data), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b1);
        stepCycle();
        checkOutput("skid_out_22", 32'(out_data), 32'h22);
        checkOutput("skid_ready", 32'(in_ready), 32'd1);
        checkOutput("skid_occ", 32'(occupancy), 32'd1);
        stepCycle();
        checkOutput("skid_empty", 32'(out_valid), 32'd0);

        // Hold under stall: FULL with 60/61, input toggling for 20 cycles.
        applyStimulus(1'b1, 8'h60, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 8'h61, 1'b0);
        stepCycle();
        protoCheckEn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(($urandom_range(0, 1) != 0), 8'($urandom), 1'b0);
            stepCycle();
            checkOutput("hold_data", 32'(out_data), 32'h60);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_occ", 32'(occupancy), 32'd2);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        stepCycle();
        checkOutput("hold_drain_61", 32'(out_data), 32'h61);
        stepCycle();
        checkOutput("hold_drain_empty", 32'(occupancy), 32'd0);
        protoCheckEn = 1'b1;

        // Drain to empty keeps the last value on out_data.
        applyStimulus(1'b1, 8'h33, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 8'h00, 1'b1);
        stepCycle();
        checkOutput("drain_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_occ", 32'(occupancy), 32'd0);
        checkOutput("drain_data", 32'(out_data), 32'h33);

        // Asynchronous reset while FULL with 44/55.
        applyStimulus(1'b1, 8'h44, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 8'h55, 1'b0);
        stepCycle();
        checkOutput("pre_rst_occ", 32'(occupancy), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_data", 32'(out_data), 32'd0);
        checkOutput("arst_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_occ", 32'(occupancy), 32'd0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        repeat (3) begin
            stepCycle();
            checkOutput("post_arst_valid", 32'(out_valid), 32'd0);
            checkOutput("post_arst_data", 32'(out_data), 32'd0);
        end

        // Random soak; the producer holds a refused beat as required.
        for (int i = 0; i < 10000; i++) begin
            if (!pendValid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
